// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
//   Pops bytes from an external first-word-fall-through FIFO and sends each
//   one as a UART 8N1 frame (start bit, 8 data bits LSB first, stop bit).
//   Each serial bit lasts SYMBOL_EDGE_TIME clock cycles. If another byte is
//   ready in the last stop cycle, the next frame follows with no idle gap.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   enable      permits new pops; a frame already started always completes
//   fifo_empty  FIFO empty flag
//   fifo_dout   FIFO read data, valid while fifo_rd_en is high
//   fifo_rd_en  single-cycle pop strobe (combinational)
//   serial_out  UART line, idles high (registered)
//   busy        high in every state except IDLE (registered)
//   bytes_sent  completed-frame counter, wraps at 16 bits
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int CLOCK_FREQ          = 125_000_000,
    parameter int BAUD_RATE           = 115_200,
    parameter int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE,
    parameter int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_dout,
    output logic        fifo_rd_en,
    output logic        serial_out,
    output logic        busy,
    output logic [15:0] bytes_sent
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [CLOCK_COUNTER_WIDTH-1:0] LAST_TICK =
        CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);

    state_t                         state_q;
    logic [CLOCK_COUNTER_WIDTH-1:0] cnt_q;
    logic [CLOCK_COUNTER_WIDTH-1:0] cnt_d;
    logic [2:0]                     bit_idx_q;
    logic [7:0]                     shift_q;
    logic                           serial_q;
    logic                           busy_q;
    logic [15:0]                    bytes_sent_q;
    logic                           last_tick;
    logic                           pop;

    assign last_tick = (cnt_q == LAST_TICK);
    // Counter restarts at every bit boundary.
    assign cnt_d     = last_tick ? '0 : cnt_q + 1'b1;

    // rst is part of the strobe so the FIFO never sees a pop while the block
    // is held in reset, even though the decode is purely combinational.
    assign pop = rst && enable && !fifo_empty &&
                 ((state_q == IDLE) || ((state_q == STOP) && last_tick));

    assign fifo_rd_en = pop;
    assign serial_out = serial_q;
    assign busy       = busy_q;
    assign bytes_sent = bytes_sent_q;

    // NOTE: all state in this block uses non-blocking assignments so every
    // register samples the pre-edge values; blocking here would create
    // order-dependent races between the counter, index and line registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            serial_q     <= 1'b1;
            busy_q       <= 1'b0;
            bytes_sent_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    bit_idx_q <= '0;
                    if (pop) begin
                        shift_q  <= fifo_dout;
                        state_q  <= START;
                        serial_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                START: begin
                    cnt_q <= cnt_d;
                    if (last_tick) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                        serial_q  <= shift_q[0];
                    end
                end
                DATA: begin
                    cnt_q <= cnt_d;
                    if (last_tick) begin
                        if (bit_idx_q == 3'd7) begin
                            state_q  <= STOP;
                            serial_q <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            serial_q  <= shift_q[bit_idx_q + 3'd1];
                        end
                    end
                end
                STOP: begin
                    cnt_q <= cnt_d;
                    if (last_tick) begin
                        bytes_sent_q <= bytes_sent_q + 16'd1;
                        if (pop) begin
                            // Back-to-back: straight into the next start bit.
                            shift_q  <= fifo_dout;
                            state_q  <= START;
                            serial_q <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    serial_q <= 1'b1;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
//   Drives fifo_uart_tx from a queue-based FIFO and predicts every output on
//   every cycle from frame-level rules: a pop at cycle p owns cycles
//   p+1..p+10*SET, bit n of the frame covers cycles p+1+n*SET.. and the
//   counter advances one cycle after the frame ends.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int SET   = 4;
    localparam int FRAME = 10 * SET;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        fifo_rd_en;
    logic        serial_out;
    logic        busy;
    logic [15:0] bytes_sent;

    fifo_uart_tx #(
        .CLOCK_FREQ (4),
        .BAUD_RATE  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .serial_out (serial_out),
        .busy       (busy),
        .bytes_sent (bytes_sent)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0]  fifo_q[$];
    int          done_q[$];
    int          cyc = 0;
    bit          have_frame = 1'b0;
    int          fp = 0;
    logic [7:0]  fbyte = 8'h00;
    logic [15:0] exp_cnt = 16'h0000;
    logic        en_req = 1'b0;
    logic        rst_req = 1'b0;
    int          last_pop_dut = 0;
    int          pop_gap = 0;

    function automatic bit in_frame(input int c);
        return have_frame && (c > fp) && (c <= fp + FRAME);
    endfunction

    function automatic logic exp_line(input int c);
        int b;
        if (!in_frame(c)) return 1'b1;
        b = (c - fp - 1) / SET;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return fbyte[b-1];
    endfunction

    // One clock cycle: check registered outputs, drive inputs, check the pop.
    task automatic step();
        logic exp_rd;
        @(negedge clk);
        cyc++;
        while (done_q.size() > 0 && done_q[0] <= cyc) begin
            exp_cnt++;
            void'(done_q.pop_front());
        end
        check("serial_out", {31'd0, serial_out}, {31'd0, exp_line(cyc)});
        check("busy", {31'd0, busy}, {31'd0, in_frame(cyc)});
        check("bytes_sent", {16'd0, bytes_sent}, {16'd0, exp_cnt});

        rst        = rst_req;
        enable     = en_req;
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = (fifo_q.size() == 0) ? 8'($urandom) : fifo_q[0];
        #1;
        exp_rd = rst && enable && (fifo_q.size() > 0) &&
                 (!have_frame || cyc >= fp + FRAME);
        check("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
        if (fifo_rd_en) begin
            pop_gap      = cyc - last_pop_dut;
            last_pop_dut = cyc;
        end
        if (exp_rd) begin
            have_frame = 1'b1;
            fp         = cyc;
            fbyte      = fifo_q.pop_front();
            done_q.push_back(cyc + FRAME + 1);
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic drain();
        int guard = 0;
        while ((fifo_q.size() > 0 || in_frame(cyc) || in_frame(cyc + 1)) && guard < 3000) begin
            step();
            guard++;
        end
        check("drain_timeout", guard, (guard < 3000) ? guard : 0);
        step();
    endtask

    initial begin
        rst        = 1'b0;
        enable     = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = 8'h00;

        // Held in reset across a few edges
        run(3);

        // Empty FIFO with enable high: line idle, no pops
        rst_req = 1'b1;
        en_req  = 1'b1;
        run(100);

        // Single byte 0xA5
        fifo_q.push_back(8'hA5);
        run(45);
        check("single_count", {16'd0, bytes_sent}, 32'd1);

        // Back-to-back 0x00 then 0xFF
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        run(85);
        check("b2b_gap", pop_gap, FRAME);
        check("b2b_count", {16'd0, bytes_sent}, 32'd3);

        // Enable drop during DATA of 0x3C with more data queued
        fifo_q.push_back(8'h3C);
        fifo_q.push_back(8'h11);
        run(15);
        en_req = 1'b0;
        run(80);
        check("endrop_count", {16'd0, bytes_sent}, 32'd4);
        check("endrop_pending", fifo_q.size(), 1);
        en_req = 1'b1;
        drain();

        // Asynchronous reset during data bit 3 of 0x55
        fifo_q.push_back(8'h55);
        begin
            int guard = 0;
            while (!(have_frame && cyc == fp + 18) && guard < 200) begin
                step();
                guard++;
            end
            check("rst_wait_timeout", guard, (guard < 200) ? guard : 0);
        end
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        rst     = 1'b0;
        rst_req = 1'b0;
        #1;
        check("rst_async_line", {31'd0, serial_out}, 32'd1);
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        check("rst_async_count", {16'd0, bytes_sent}, 32'd0);
        check("rst_async_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        have_frame = 1'b0;
        fifo_q.delete();
        done_q.delete();
        exp_cnt = 16'h0000;
        run(3);
        rst_req = 1'b1;
        run(30);

        // Counter wrap from 0xFFFF
        force dut.bytes_sent_q = 16'hFFFF;
        exp_cnt = 16'hFFFF;
        step();
        release dut.bytes_sent_q;
        run(2);
        fifo_q.push_back(8'hC3);
        run(45);
        check("wrap_count", {16'd0, bytes_sent}, 32'd0);

        // Randomised traffic with enable toggling
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0 && fifo_q.size() < 4)
                fifo_q.push_back(8'($urandom));
            if ($urandom_range(31) == 0)
                en_req = ($urandom_range(3) != 0);
            step();
        end
        en_req = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLOCK_FREQ, default 125_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200, serial bit rate in bits/s.
REQ-003 Parameter SYMBOL_EDGE_TIME, default CLOCK_FREQ/BAUD_RATE, clock cycles per serial bit; legal values are integers of 2 or more.
REQ-004 Parameter CLOCK_COUNTER_WIDTH, default $clog2(SYMBOL_EDGE_TIME), width of the bit-period counter.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  when high, the block may pop new bytes from the FIFO.
REQ-008 fifo_empty  input  1  FIFO empty flag.
REQ-009 fifo_dout  input  8  FIFO read data; valid combinationally in the same cycle that fifo_rd_en is high and fifo_empty is low.
REQ-010 fifo_rd_en  output  1  FIFO pop strobe; a single-cycle pulse per byte.
REQ-011 serial_out  output  1  UART 8N1 line; idles high.
REQ-012 busy  output  1  high whenever a frame is in progress (any state other than IDLE).
REQ-013 bytes_sent  output  16  count of completed frames; wraps from 0xFFFF to 0.

Function
REQ-014 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-015 fifo_rd_en SHALL be combinational: it equals enable && !fifo_empty && (state==IDLE || last cycle of STOP), and it SHALL never be high while fifo_empty is high.
REQ-016 In any cycle with fifo_rd_en high, the block SHALL capture fifo_dout into an 8-bit shift register and enter START on the next edge.
REQ-017 START SHALL drive serial_out=0 for exactly SYMBOL_EDGE_TIME cycles.
REQ-018 DATA SHALL drive the 8 data bits LSB first, each for exactly SYMBOL_EDGE_TIME cycles, using a 3-bit bit index.
REQ-019 STOP SHALL drive serial_out=1 for exactly SYMBOL_EDGE_TIME cycles.
REQ-020 The bit-period counter SHALL count 0..SYMBOL_EDGE_TIME-1 and reset to 0 on every bit boundary.
REQ-021 In IDLE, serial_out SHALL be 1.
REQ-022 Latency: serial_out SHALL fall on the first edge after the pop cycle.
REQ-023 A frame SHALL occupy exactly 10*SYMBOL_EDGE_TIME cycles.
REQ-024 Back-to-back: if a pop occurs in the last STOP cycle, the next START SHALL begin on the following edge with no idle gap; otherwise the block SHALL return to IDLE.
REQ-025 Deasserting enable mid-frame SHALL NOT abort the current frame; only new pops are inhibited.
REQ-026 Changes on fifo_empty or fifo_dout outside the pop cycle SHALL NOT affect the frame in progress.
REQ-027 bytes_sent SHALL increment by 1 on the edge that leaves the last STOP cycle.
REQ-028 busy SHALL be low only in IDLE, including the single idle cycle between non-back-to-back frames.

Reset
REQ-029 While rst is low, the block SHALL immediately (asynchronously) force: state=IDLE, serial_out=1, busy=0, shift register=0, counters=0, bytes_sent=0.
REQ-030 fifo_rd_en SHALL be 0 while rst is low.
REQ-031 Reset asserted mid-frame SHALL abort the frame and drop the byte, with the line high immediately.
REQ-032 After rst deasserts, the first pop SHALL occur no earlier than the first clk edge.

Verification (CLOCK_FREQ=4, BAUD_RATE=1, so SYMBOL_EDGE_TIME=4)
REQ-033 Single byte: FIFO holds 0xA5, enable=1 -> one fifo_rd_en pulse; serial_out shows 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles; bytes_sent=1; busy high for 40 cycles.
REQ-034 Back-to-back: FIFO holds 0x00 then 0xFF -> second pop in the last STOP cycle; the second start bit follows directly, with no idle cycle; total 80 cycles.
REQ-035 Empty FIFO: fifo_empty=1 for 100 cycles -> fifo_rd_en=0, serial_out=1, busy=0 throughout.
REQ-036 Enable drop: enable falls during DATA of byte 0x3C with more data in the FIFO -> 0x3C completes; no further pop until enable rises again.
REQ-037 Mid-frame reset: rst low during bit 3 of 0x55 -> serial_out=1 and busy=0 with no clock edge needed; bytes_sent=0; after release with an empty FIFO the line stays high.
REQ-038 Counter wrap: preload via 65536 frames, or force bytes_sent=0xFFFF -> the next completed frame gives bytes_sent=0x0000.
